// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   rx_state_t         receiver FSM states
//   PAR_EVEN / PAR_ODD encoding of the PAR_TYP input
//   START_BIT/STOP_BIT line levels of the frame delimiters
//   maj3()             2-of-3 majority vote used by the bit sampler
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: signal bundle between a serial line source / word consumer
// (master) and the uart_rx receiver (slave).
//   RX_IN       serial line, idle high
//   par_en      1 = frame carries a parity bit
//   PAR_TYP     PAR_EVEN / PAR_ODD
//   P_Data      last error-free received word
//   Data_Valid  one-cycle strobe, P_Data holds a new word
//   par_err     parity mismatch on the last frame
//   stp_err     stop bit sampled low on the last frame
//   busy        receiver FSM outside IDLE
//   state       receiver FSM state, exported for observation
//
// Handshake: Data_Valid is a valid-only strobe with no ready. The word is
// presented for exactly one cycle with Data_Valid high; the consumer has no
// way to stall the receiver and must capture P_Data in that cycle (P_Data
// itself holds until the next good frame).
interface uart_rx_if #(
    parameter int FRAME_WIDTH = 8
);
    import uart_pkg::*;

    logic                   RX_IN;
    logic                   par_en;
    logic                   PAR_TYP;
    logic [FRAME_WIDTH-1:0] P_Data;
    logic                   Data_Valid;
    logic                   par_err;
    logic                   stp_err;
    logic                   busy;
    rx_state_t              state;

    modport master (
        output RX_IN, par_en, PAR_TYP,
        input  P_Data, Data_Valid, par_err, stp_err, busy, state
    );

    modport slave (
        input  RX_IN, par_en, PAR_TYP,
        output P_Data, Data_Valid, par_err, stp_err, busy, state
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit edge counter and 3-sample majority vote.
//   clk, reset     system clock, synchronous active-high reset
//   rx_in          serial line (already synchronous to clk)
//   run            count this cycle; when low the counter is held at 0
//   sample_bit     majority of rx_in at counts M-1, M, M+1 (valid with strobe)
//   sample_strobe  high at count M+1, the bit decision point
//   bit_wrap       high at count OVERSAMPLE-1, the last cycle of a bit
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8,
    parameter int CNT_WIDTH  = $clog2(OVERSAMPLE)
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_in,
    input  logic run,
    output logic sample_bit,
    output logic sample_strobe,
    output logic bit_wrap
);

    localparam logic [CNT_WIDTH-1:0] MID      = CNT_WIDTH'(OVERSAMPLE / 2);
    localparam logic [CNT_WIDTH-1:0] MID_M1   = CNT_WIDTH'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] MID_P1   = CNT_WIDTH'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(OVERSAMPLE - 1);

    logic [CNT_WIDTH-1:0] edge_cnt;
    logic                 s_early;
    logic                 s_mid;

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cnt <= '0;
            s_early  <= 1'b1;
            s_mid    <= 1'b1;
        end else begin
            if (!run || bit_wrap) edge_cnt <= '0;
            else                  edge_cnt <= edge_cnt + 1'b1;
            if (edge_cnt == MID_M1) s_early <= rx_in;
            if (edge_cnt == MID)    s_mid   <= rx_in;
        end
    end

    // The third vote is the live line at M+1, so the decision needs no
    // extra register stage.
    always_comb begin
        sample_strobe = (edge_cnt == MID_P1);
        bit_wrap      = (edge_cnt == CNT_LAST);
        sample_bit    = maj3(s_early, s_mid, rx_in);
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start 0, FRAME_WIDTH data bits
// LSB-first, optional parity, stop 1).
//   clk, reset  system clock, synchronous active-high reset
//   rx          uart_rx_if.slave: RX_IN/par_en/PAR_TYP in; P_Data,
//               Data_Valid, par_err, stp_err, busy, state out
// Build option: UART_RX_SYNC_EN adds a 2-flop synchronizer (reset to 1) on
// RX_IN; every latency grows by 2 cycles. Without it RX_IN must already be
// synchronous to clk.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FRAME_WIDTH = 8,
    parameter int OVERSAMPLE  = 8,
    parameter int CNT_WIDTH   = $clog2(OVERSAMPLE)
) (
    input logic     clk,
    input logic     reset,
    uart_rx_if.slave rx
);

    localparam int                BIT_CNT_W = $clog2(FRAME_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_WIDTH - 1);

    rx_state_t              state, state_nx;
    logic                   rx_s;
    logic                   run;
    logic                   sample_bit, sample_strobe, bit_wrap;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [FRAME_WIDTH-1:0] shift_q;
    logic [FRAME_WIDTH-1:0] p_data_q;
    logic                   par_en_q, par_typ_q, par_fail;
    logic                   data_valid_q, par_err_q, stp_err_q;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx.RX_IN};
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = rx.RX_IN;
`endif

    // The counter runs whenever the FSM will be busy next cycle: this makes
    // the start-edge cycle count 0, and clears the counter as soon as STOP
    // or a glitching START returns to IDLE.
    assign run = (state_nx != IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_sampler (
        .clk           (clk),
        .reset         (reset),
        .rx_in         (rx_s),
        .run           (run),
        .sample_bit    (sample_bit),
        .sample_strobe (sample_strobe),
        .bit_wrap      (bit_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (rx_s == START_BIT) state_nx = START;
            START: begin
                if (sample_strobe && sample_bit != START_BIT) state_nx = IDLE;
                else if (bit_wrap)                              state_nx = DATA;
            end
            DATA:   if (bit_wrap && bit_cnt == LAST_BIT)
                        state_nx = par_en_q ? PARITY : STOP;
            PARITY: if (bit_wrap) state_nx = STOP;
            // Leave at the decision point so a start edge right after the
            // stop bit is not missed.
            STOP:   if (sample_strobe) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt      <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_fail     <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (state)
                IDLE: if (rx_s == START_BIT) begin
                    par_en_q  <= rx.par_en;
                    par_typ_q <= rx.PAR_TYP;
                    par_fail  <= 1'b0;
                    bit_cnt   <= '0;
                end
                // Errors of the previous frame are kept until a start bit
                // survives the vote; glitches leave them untouched.
                START: if (sample_strobe && sample_bit == START_BIT) begin
                    par_err_q <= 1'b0;
                    stp_err_q <= 1'b0;
                end
                DATA: begin
                    if (sample_strobe) shift_q <= {sample_bit, shift_q[FRAME_WIDTH-1:1]};
                    if (bit_wrap)      bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY: if (sample_strobe && (sample_bit != (^shift_q ^ par_typ_q)))
                    par_fail <= 1'b1;
                STOP: if (sample_strobe) begin
                    par_err_q <= par_fail;
                    stp_err_q <= (sample_bit != STOP_BIT);
                    if (!par_fail && sample_bit == STOP_BIT) begin
                        p_data_q     <= shift_q;
                        data_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx.P_Data     = p_data_q;
    assign rx.Data_Valid = data_valid_q;
    assign rx.par_err    = par_err_q;
    assign rx.stp_err    = stp_err_q;
    assign rx.busy       = (state != IDLE);
    assign rx.state      = state;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx. A line driver emulates the
// transmitter; a Data_Valid monitor checks delivered words against an
// expected queue.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int FW = 8;
    localparam int OS = 8;
`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LAT_PAR   = 86 + SYNC_LAT;
    localparam int LAT_NOPAR = 78 + SYNC_LAT;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if #(.FRAME_WIDTH(FW)) rx_if ();

    uart_rx #(
        .FRAME_WIDTH (FW),
        .OVERSAMPLE  (OS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx_if)
    );

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [FW-1:0] exp_q[$];
    int            dv_cnt      = 0;
    int            last_dv_cyc = 0;

    always @(negedge clk) begin
        if (rx_if.Data_Valid === 1'b1) begin
            dv_cnt++;
            last_dv_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_dv", 32'(rx_if.P_Data), 32'hFFFF_FFFF);
            else                   check("dv_data", 32'(rx_if.P_Data), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end on a negedge.
    task automatic drive_bit(input logic b);
        rx_if.RX_IN = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [FW-1:0] d, input bit with_par,
                              input logic par_bit, input logic stop_bit, output int t0);
        t0 = cyc;
        drive_bit(START_BIT);
        for (int i = 0; i < FW; i++) drive_bit(d[i]);
        if (with_par) drive_bit(par_bit);
        drive_bit(stop_bit);
        rx_if.RX_IN = 1'b1;
    endtask

    // Well-formed frame as the transmitter would produce it.
    task automatic tx_frame(input logic [FW-1:0] d, input bit with_par,
                            input logic typ, output int t0);
        send_frame(d, with_par, (^d) ^ typ, STOP_BIT, t0);
    endtask

    task automatic check_idle_outputs(input string tag, input logic [FW-1:0] pd,
                                      input logic pe, input logic se);
        check({tag, "_p_data"},  32'(rx_if.P_Data),  32'(pd));
        check({tag, "_par_err"}, 32'(rx_if.par_err), 32'(pe));
        check({tag, "_stp_err"}, 32'(rx_if.stp_err), 32'(se));
        check({tag, "_busy"},    32'(rx_if.busy),    32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int dv_before;

        reset          = 1'b1;
        rx_if.RX_IN    = 1'b1;
        rx_if.par_en   = 1'b0;
        rx_if.PAR_TYP  = PAR_EVEN;
        repeat (3) @(negedge clk);
        check("rst_dv",    32'(rx_if.Data_Valid), 32'd0);
        check("rst_state", 32'(rx_if.state),      32'(IDLE));
        check_idle_outputs("rst", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: good 0xA5, even parity (bit 0)
        rx_if.par_en  = 1'b1;
        rx_if.PAR_TYP = PAR_EVEN;
        dv_before = dv_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, STOP_BIT, t0);
        repeat (4) @(negedge clk);
        check("t1_dv_count", 32'(dv_cnt - dv_before), 32'd1);
        check("t1_latency",  32'(last_dv_cyc - t0),   32'(LAT_PAR));
        check_idle_outputs("t1", 8'hA5, 1'b0, 1'b0);

        // 2: 0xA5 with parity bit 0 while odd parity expects 1
        rx_if.PAR_TYP = PAR_ODD;
        dv_before = dv_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, STOP_BIT, t0);
        repeat (4) @(negedge clk);
        check("t2_dv_count", 32'(dv_cnt - dv_before), 32'd0);
        check_idle_outputs("t2", 8'hA5, 1'b1, 1'b0);

        // 3: 3-cycle glitch in IDLE
        dv_before = dv_cnt;
        rx_if.RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_busy_during", 32'(rx_if.busy), 32'd1);
        rx_if.RX_IN = 1'b1;
        repeat (OS) @(negedge clk);
        check("t3_dv_count", 32'(dv_cnt - dv_before), 32'd0);
        check_idle_outputs("t3", 8'hA5, 1'b1, 1'b0);

        // 4: 0x3C, no parity, stop bit low
        rx_if.par_en = 1'b0;
        dv_before = dv_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, t0);
        repeat (20) @(negedge clk);
        check("t4_dv_count", 32'(dv_cnt - dv_before), 32'd0);
        check_idle_outputs("t4", 8'hA5, 1'b0, 1'b1);

        // 5: good 0x81 without parity clears stp_err
        dv_before = dv_cnt;
        exp_q.push_back(8'h81);
        tx_frame(8'h81, 1'b0, PAR_EVEN, t0);
        repeat (4) @(negedge clk);
        check("t5_dv_count", 32'(dv_cnt - dv_before), 32'd1);
        check("t5_latency",  32'(last_dv_cyc - t0),   32'(LAT_NOPAR));
        check_idle_outputs("t5", 8'h81, 1'b0, 1'b0);

        // 6: back-to-back odd-parity frames 0x00, 0xFF, 0x55
        rx_if.par_en  = 1'b1;
        rx_if.PAR_TYP = PAR_ODD;
        dv_before = dv_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        tx_frame(8'h00, 1'b1, PAR_ODD, t0);
        tx_frame(8'hFF, 1'b1, PAR_ODD, t0);
        tx_frame(8'h55, 1'b1, PAR_ODD, t0);
        repeat (4) @(negedge clk);
        check("t6_dv_count", 32'(dv_cnt - dv_before), 32'd3);
        check("t6_latency",  32'(last_dv_cyc - t0),   32'(LAT_PAR));
        check_idle_outputs("t6", 8'h55, 1'b0, 1'b0);

        // 7: reset during DATA of 0x5A, then a fresh 0x96 frame
        rx_if.PAR_TYP = PAR_EVEN;
        dv_before = dv_cnt;
        drive_bit(START_BIT);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        check("t7_state_data", 32'(rx_if.state), 32'(DATA));
        reset       = 1'b1;
        rx_if.RX_IN = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t7_rst_dv", 32'(rx_if.Data_Valid), 32'd0);
        check_idle_outputs("t7_rst", 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h96);
        tx_frame(8'h96, 1'b1, PAR_EVEN, t0);
        repeat (4) @(negedge clk);
        check("t7_dv_count", 32'(dv_cnt - dv_before), 32'd1);
        check_idle_outputs("t7", 8'h96, 1'b0, 1'b0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream consumer of the UART transmitter's TX_OUT line.
- Oversamples RX_IN, detects and qualifies the start bit, then shifts in FRAME_WIDTH data bits LSB-first.
- Checks the optional parity bit and the stop bit.
- Presents the recovered parallel word with a one-cycle Data_Valid pulse. Frame format (start 0, data, optional parity, stop 1) matches the transmitter exactly.

Parameters:
- FRAME_WIDTH, 8, data bits per frame.
- OVERSAMPLE, 8, clk cycles per bit period; must be an even number ≥ 4.
- CNT_WIDTH, $clog2(OVERSAMPLE), width of the edge counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- RX_IN  in  1  serial line; idle high.
- par_en  in  1  1 = frame carries a parity bit.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_Data  out  FRAME_WIDTH  received word; updated only on good frames.
- Data_Valid  out  1  one-cycle pulse: P_Data holds a new, error-free word.
- par_err  out  1  parity mismatch on the last frame.
- stp_err  out  1  stop bit sampled low on the last frame.
- busy  out  1  high while the FSM is outside IDLE.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: P_Data=0, Data_Valid=0, par_err=0, stp_err=0, busy=0, FSM=IDLE, counters=0.
- Edge counter: counts 0..OVERSAMPLE-1 within each bit, then wraps. A bit counter advances on each wrap.
- Bit sampling: majority vote of RX_IN at edge counts M-1, M, M+1, where M=OVERSAMPLE/2. The bit decision is made at count M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on RX_IN==0, go to START. Edge counter=0 in that same cycle (t0). par_en and PAR_TYP are latched here; later changes are ignored until the next frame.
  - START: if the voted bit is 1 (glitch), return to IDLE with no output and no error change. Otherwise go to DATA at the wrap.
  - DATA: shift the voted bit into the shift register LSB-first. After FRAME_WIDTH bits, go to PARITY if the latched par_en is set, else STOP.
  - PARITY: compute expected parity = XOR(data) ^ latched PAR_TYP. A mismatch sets an internal parity-fail flag. Go to STOP at the wrap.
  - STOP: at the decision point (count M+1), return to IDLE immediately without waiting for the wrap. This allows back-to-back frames whose next start edge follows the stop bit.
- Frame completion (the cycle after the STOP decision):
  - par_err and stp_err are registered.
  - If both are 0: P_Data ← shift register and Data_Valid=1 for exactly one cycle.
  - If either is set: P_Data holds its previous value and Data_Valid stays 0.
- Error flags hold until the next qualified start bit, which clears both.
- Latency: the Data_Valid cycle is t0 + (N-1)·OVERSAMPLE + M + 2, with N = FRAME_WIDTH+2 (+1 with parity). At defaults with parity: t0+86. Without parity: t0+78.
- Reset mid-frame: the frame is discarded and all outputs return to their reset values on the next clk edge.
- RX_IN low at reset release: treated as a start edge in the first post-reset cycle.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: RX_IN passes through a 2-flop synchronizer, reset to 1, before any logic. All latencies grow by 2 cycles.
- Undefined: RX_IN is used directly and is required to be synchronous to clk.

Decomposition:
- Shared package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - PAR_EVEN=0 and PAR_ODD=1;
  - START_BIT=0 and STOP_BIT=1, which the transmitter also uses.
- One sub-module: uart_rx_sampler. It contains the edge counter and the 3-sample majority vote, and outputs sample_bit, sample_strobe (at count M+1) and bit_wrap.

Test Plan:
- 0xA5, par_en=1, PAR_TYP=0, parity bit 0, stop 1 → P_Data=0xA5, Data_Valid pulse at t0+86, par_err=0, stp_err=0.
- 0xA5 sent with parity bit 0 while PAR_TYP=1 (expected 1) → par_err=1, no Data_Valid, P_Data keeps the prior value.
- 0x3C, par_en=0, stop bit driven 0 → stp_err=1, no Data_Valid. The next good frame 0x81 clears stp_err and delivers 0x81.
- RX_IN low for 3 cycles then high in IDLE → returns to IDLE, no output, busy drops within OVERSAMPLE cycles.
- Loopback from the transmitter with par_en=1, PAR_TYP=1, words 0x00, 0xFF, 0x55 sent back-to-back → three Data_Valid pulses with matching data, no errors.
- reset asserted during DATA of 0x5A, then a fresh 0x96 frame → all outputs 0 after reset; only 0x96 is delivered.
